// File: rtl/packet_to_flits_pkg.sv
// Shared flit format for the NIC transmit serializer: widths, flit-type codes and FSM states.
package packet_to_flits_pkg;

    localparam int unsigned FLIT_WIDTH        = 32;
    localparam int unsigned MAX_PACKET_LENGHT = 8;
    localparam int unsigned FLIT_TYPE_BITS    = 2;

    typedef enum logic [FLIT_TYPE_BITS-1:0] {
        HEAD_FLIT      = 2'b00,
        BODY_FLIT      = 2'b01,
        TAIL_FLIT      = 2'b10,
        HEAD_TAIL_FLIT = 2'b11
    } flit_type_e;

    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        CHECK   = 3'b010,
        SENDING = 3'b100
    } state_e;

    // Flit type lives in the top FLIT_TYPE_BITS of every flit.
    function automatic flit_type_e flit_type(input logic [FLIT_WIDTH-1:0] flit);
        return flit_type_e'(flit[FLIT_WIDTH-1 -: FLIT_TYPE_BITS]);
    endfunction

endpackage

// File: rtl/packet_to_flits_credit_counter.sv
// Router input-buffer credit counter: decrements per flit sent, increments per returned credit, saturates at N_CREDITS.
module credit_counter #(
    parameter int unsigned N_CREDITS     = 4,
    parameter int unsigned N_BITS_CREDIT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inc_i,
    input  logic                     dec_i,
    output logic [N_BITS_CREDIT-1:0] count_o,
    output logic                     nonzero_o
);

    logic [N_BITS_CREDIT-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (dec_i && !inc_i) begin
            count_d = count_q - 1'b1;
        end else if (inc_i && !dec_i && (count_q != N_BITS_CREDIT'(N_CREDITS))) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= N_BITS_CREDIT'(N_CREDITS);
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign nonzero_o = (count_q != '0);

endmodule

// File: rtl/packet_to_flits.sv
// NIC transmit serializer: takes a whole packet in one handshake and streams it flit by flit to the router,
// gated by credits and, for head flits, by the router input buffer being free.
module packet_to_flits
    import packet_to_flits_pkg::*;
#(
    parameter int unsigned N_BITS_POINTER = 3,
    parameter int unsigned N_CREDITS      = 4,
    parameter int unsigned N_BITS_CREDIT  = 3
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    r_msg_to_pkt_i,
    input  logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] in_link_i,
    output logic                                    stall_msg_to_pkt_o,
    output logic [FLIT_WIDTH-1:0]                   out_link_o,
    output logic                                    is_valid_o,
    input  logic                                    credit_signal_i,
    input  logic                                    free_signal_i,
    output logic                                    error_o
);

    state_e                    state_q, state_d;
    logic [FLIT_WIDTH-1:0]     buffer_q [MAX_PACKET_LENGHT];
    logic [N_BITS_POINTER-1:0] rd_ptr_q, rd_ptr_d;
    logic                      dst_free_q, dst_free_d;
    logic [N_BITS_CREDIT-1:0]  credit_count;
    logic                      credit_nz;
    logic                      send, last, head_ok, accept;
    flit_type_e                cur_type, head_type;

    credit_counter #(
        .N_CREDITS     (N_CREDITS),
        .N_BITS_CREDIT (N_BITS_CREDIT)
    ) u_credit_counter (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (credit_signal_i),
        .dec_i     (send),
        .count_o   (credit_count),
        .nonzero_o (credit_nz)
    );

    assign head_type  = flit_type(buffer_q[0]);
    assign cur_type   = flit_type(buffer_q[rd_ptr_q]);
    assign head_ok    = (head_type == HEAD_FLIT) || (head_type == HEAD_TAIL_FLIT);
    assign accept     = (state_q == IDLE) && r_msg_to_pkt_i;
    assign send       = (state_q == SENDING) && credit_nz && ((rd_ptr_q != '0) || dst_free_q);
    assign last       = (cur_type == TAIL_FLIT) || (cur_type == HEAD_TAIL_FLIT) ||
                        (rd_ptr_q == N_BITS_POINTER'(MAX_PACKET_LENGHT-1));
    assign out_link_o = buffer_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (r_msg_to_pkt_i) state_d = CHECK;
            CHECK:   state_d = head_ok ? SENDING : IDLE;
            SENDING: if (send && last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_msg_to_pkt_o = (state_q != IDLE);
        is_valid_o         = send;
        error_o            = (state_q == CHECK) && !head_ok;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (accept) begin
            rd_ptr_d = '0;
        end else if (send) begin
            rd_ptr_d = last ? '0 : rd_ptr_q + 1'b1;
        end
    end

    // A head send and a free notification in the same cycle leave the router marked busy.
    always_comb begin
        dst_free_d = dst_free_q;
        if (send && (rd_ptr_q == '0)) begin
            dst_free_d = 1'b0;
        end else if (free_signal_i) begin
            dst_free_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q   <= '0;
            dst_free_q <= 1'b1;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            dst_free_q <= dst_free_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned i = 0; i < MAX_PACKET_LENGHT; i++) begin
                buffer_q[i] <= in_link_i[i*FLIT_WIDTH +: FLIT_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_packet_to_flits.sv
// Scoreboard bench for packet_to_flits: expected flits queued at request time, compared as they appear.
module tb_packet_to_flits;
    import packet_to_flits_pkg::*;

    localparam int W = FLIT_WIDTH;
    localparam int L = MAX_PACKET_LENGHT;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           r_msg = 1'b0;
    logic [L*W-1:0] in_link = '0;
    logic           stall;
    logic [W-1:0]   out_link;
    logic           is_valid;
    logic           credit_signal;
    logic           free_sig = 1'b0;
    logic           error;

    logic           auto_credit = 1'b0;
    logic           credit_man = 1'b0;
    logic           credit_auto = 1'b0;
    logic [1:0]     pipe = '0;

    logic [W-1:0]   exp_q [$];
    logic [W-1:0]   exp_flit;
    logic [W-1:0]   pkt [L];
    int             checks = 0;
    int             passes = 0;
    int             valid_cnt = 0;
    int             err_cnt = 0;

    assign credit_signal = credit_man | credit_auto;

    always #5 clk = ~clk;

    packet_to_flits #(
        .N_BITS_POINTER (3),
        .N_CREDITS      (4),
        .N_BITS_CREDIT  (3)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .r_msg_to_pkt_i     (r_msg),
        .in_link_i          (in_link),
        .stall_msg_to_pkt_o (stall),
        .out_link_o         (out_link),
        .is_valid_o         (is_valid),
        .credit_signal_i    (credit_signal),
        .free_signal_i      (free_sig),
        .error_o            (error)
    );

    // Output monitor / scoreboard, plus the router model returning a credit two cycles after each flit.
    initial forever begin
        @(negedge clk);
        if (is_valid) begin
            valid_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL flit_unexpected got=%h expected=none", out_link);
            end else begin
                exp_flit = exp_q.pop_front();
                if (out_link !== exp_flit) $display("FAIL flit_data got=%h expected=%h", out_link, exp_flit);
                else passes++;
            end
        end
        if (error) err_cnt++;
        pipe = {pipe[0], is_valid && auto_credit};
        credit_auto = pipe[1];
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] mk_flit(input flit_type_e t, input logic [W-FLIT_TYPE_BITS-1:0] p);
        return {t, p};
    endfunction

    task automatic request(input int n_exp);
        int guard = 0;
        while (stall !== 1'b0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 50) $display("FAIL request_ready stall=%b expected=0", stall);
        else passes++;
        for (int i = 0; i < L; i++) in_link[i*W +: W] = pkt[i];
        for (int i = 0; i < n_exp; i++) exp_q.push_back(pkt[i]);
        r_msg = 1'b1;
        @(negedge clk);
        r_msg = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while ((exp_q.size() != 0 || stall !== 1'b0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 100) $display("FAIL %s_drain pending=%0d stall=%b expected pending=0 stall=0", name, exp_q.size(), stall);
        else passes++;
    endtask

    task automatic pulse_free();
        free_sig = 1'b1;
        @(negedge clk);
        free_sig = 1'b0;
    endtask

    task automatic check_credits(input string name, input int expv);
        checks++;
        if (int'(dut.credit_count) !== expv) $display("FAIL %s_credits got=%0d expected=%0d", name, dut.credit_count, expv);
        else passes++;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({stall, is_valid, error} !== 3'b000) $display("FAIL reset_outputs got=%b expected=000", {stall, is_valid, error});
        else passes++;
        check_credits("reset", 4);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stream();
        int v0 = valid_cnt;
        auto_credit = 1'b1;
        pkt[0] = mk_flit(HEAD_FLIT, 30'h0001);
        for (int i = 1; i < 4; i++) pkt[i] = mk_flit(BODY_FLIT, 30'(32'h100 + i));
        pkt[4] = mk_flit(TAIL_FLIT, 30'h0fff);
        for (int i = 5; i < L; i++) pkt[i] = mk_flit(BODY_FLIT, 30'h3bad);
        request(5);
        drain("stream");
        repeat (4) @(negedge clk);
        checks++;
        if (valid_cnt - v0 !== 5) $display("FAIL stream_count got=%0d expected=5", valid_cnt - v0);
        else passes++;
        check_credits("stream", 4);
    endtask

    task automatic test_free_wait();
        int v0;
        for (int k = 0; k < 2; k++) begin
            v0 = valid_cnt;
            pkt[0] = mk_flit(HEAD_TAIL_FLIT, 30'(32'h2000 + k));
            pkt[1] = mk_flit(TAIL_FLIT, 30'h3bad);
            request(1);
            repeat (5) @(negedge clk);
            checks++;
            if (valid_cnt !== v0) $display("FAIL free_wait_hold got=%0d expected=%0d", valid_cnt, v0);
            else passes++;
            pulse_free();
            drain("free_wait");
            checks++;
            if (valid_cnt - v0 !== 1) $display("FAIL free_wait_count got=%0d expected=1", valid_cnt - v0);
            else passes++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_no_tail();
        int v0;
        auto_credit = 1'b0;
        repeat (3) @(negedge clk);
        check_credits("no_tail_start", 4);
        pulse_free();
        v0 = valid_cnt;
        pkt[0] = mk_flit(HEAD_FLIT, 30'h3000);
        for (int i = 1; i < L; i++) pkt[i] = mk_flit(BODY_FLIT, 30'(32'h3000 + i));
        request(8);
        repeat (10) @(negedge clk);
        checks++;
        if ({valid_cnt - v0, is_valid, stall} !== {32'd4, 1'b0, 1'b1})
            $display("FAIL no_tail_hold flits=%0d valid=%b stall=%b expected flits=4 valid=0 stall=1", valid_cnt - v0, is_valid, stall);
        else passes++;
        credit_man = 1'b1;
        repeat (8) @(negedge clk);
        credit_man = 1'b0;
        drain("no_tail");
        checks++;
        if (valid_cnt - v0 !== 8) $display("FAIL no_tail_count got=%0d expected=8", valid_cnt - v0);
        else passes++;
        check_credits("no_tail_end", 4);
    endtask

    task automatic test_bad_head();
        int v0 = valid_cnt;
        int e0 = err_cnt;
        pkt[0] = mk_flit(BODY_FLIT, 30'h4000);
        pkt[1] = mk_flit(TAIL_FLIT, 30'h4001);
        request(0);
        repeat (4) @(negedge clk);
        checks++;
        if ({err_cnt - e0, valid_cnt - v0, stall} !== {32'd1, 32'd0, 1'b0})
            $display("FAIL bad_head errors=%0d flits=%0d stall=%b expected errors=1 flits=0 stall=0", err_cnt - e0, valid_cnt - v0, stall);
        else passes++;
    endtask

    task automatic test_credit_same_cycle();
        pulse_free();
        pkt[0] = mk_flit(HEAD_FLIT, 30'h5000);
        pkt[1] = mk_flit(BODY_FLIT, 30'h5001);
        pkt[2] = mk_flit(TAIL_FLIT, 30'h5002);
        request(3);
        drain("cred_setup");
        check_credits("cred_setup", 1);
        pulse_free();
        pkt[0] = mk_flit(HEAD_FLIT, 30'h5100);
        pkt[1] = mk_flit(BODY_FLIT, 30'h5101);
        pkt[2] = mk_flit(BODY_FLIT, 30'h5102);
        pkt[3] = mk_flit(TAIL_FLIT, 30'h5103);
        request(4);
        @(negedge clk);
        credit_man = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (is_valid !== 1'b1) $display("FAIL cred_no_bubble cycle=%0d valid=%b expected=1", i, is_valid);
            else passes++;
            check_credits("cred_same_cycle", 1);
            @(negedge clk);
        end
        credit_man = 1'b0;
        check_credits("cred_after", 1);
        credit_man = 1'b1;
        repeat (5) @(negedge clk);
        credit_man = 1'b0;
        check_credits("cred_saturate", 4);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int guard = 0;
        int v0;
        pulse_free();
        auto_credit = 1'b1;
        pkt[0] = mk_flit(HEAD_FLIT, 30'h6000);
        for (int i = 1; i < 4; i++) pkt[i] = mk_flit(BODY_FLIT, 30'(32'h6000 + i));
        pkt[4] = mk_flit(TAIL_FLIT, 30'h6004);
        request(2);
        while (n < 2 && guard < 50) begin
            @(negedge clk);
            if (is_valid) n++;
            guard++;
        end
        checks++;
        if (n != 2) $display("FAIL reset_mid_start flits=%0d expected=2", n);
        else passes++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        auto_credit = 1'b0;
        #1;
        checks++;
        if ({stall, is_valid, error} !== 3'b000) $display("FAIL reset_mid_outputs got=%b expected=000", {stall, is_valid, error});
        else passes++;
        check_credits("reset_mid", 4);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) $display("FAIL reset_mid_pending got=%0d expected=0", exp_q.size());
        else passes++;
        auto_credit = 1'b1;
        v0 = valid_cnt;
        request(5);
        drain("reset_mid");
        repeat (4) @(negedge clk);
        checks++;
        if (valid_cnt - v0 !== 5) $display("FAIL reset_mid_count got=%0d expected=5", valid_cnt - v0);
        else passes++;
        check_credits("reset_mid_end", 4);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_free_wait();
        test_no_tail();
        test_bad_head();
        test_credit_same_cycle();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
